// File: rtl/pulsar_pkg.sv
// Shared types and helpers for the pulse_fader threshold sequencer.
package pulsar_pkg;

    typedef enum logic {IDLE, SWEEP} fader_state_t;

    // Start level of channel i so that N channels are spread evenly over 2^w.
    function automatic int stagger_level(input int i, input int w, input int n);
        return (i * (1 << w) / n) % (1 << w);
    endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Free-running divider producing one tick every tick_div enabled clocks.
module tick_prescaler #(
    parameter int tick_div = 1024
) (
    input  logic clk,
    input  logic rst,
    input  logic enable,
    input  logic clear,
    output logic tick
);

    localparam int CW = (tick_div > 1) ? $clog2(tick_div) : 1;
    localparam logic [CW-1:0] LAST = CW'(tick_div - 1);

    logic [CW-1:0] count;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count <= '0;
        end else if (clear || !enable || count == LAST) begin
            count <= '0;
        end else begin
            count <= count + 1'b1;
        end
    end

    assign tick = enable && (count == LAST);

endmodule

// File: rtl/pulse_fader.sv
// Triangle-wave brightness sequencer feeding the pwm threshold write port,
// one channel written per clock after every prescaled tick.
module pulse_fader
    import pulsar_pkg::*;
#(
    parameter int pwm_width = 4,
    parameter int num_pwm   = 4,
    parameter int tick_div  = 1024
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       enable,
    input  logic                       resync,
    output logic [pwm_width-1:0]       new_thres,
    output logic [$clog2(num_pwm)-1:0] sel_thres,
    output logic                       set_thres,
    output logic                       busy
);

    localparam int W  = pwm_width;
    localparam int N  = num_pwm;
    localparam int SW = $clog2(num_pwm);
    localparam logic [W-1:0]  MAX_LEVEL = '1;
    localparam logic [SW-1:0] LAST_SEL  = SW'(N - 1);

    fader_state_t  state;
    logic          init_pending;
    logic          tick;
    logic [W-1:0]  level         [N];
    logic          dir_down      [N];
    logic [W-1:0]  level_next    [N];
    logic          dir_down_next [N];
    logic [SW-1:0] sel_inc;

    tick_prescaler #(.tick_div(tick_div)) u_prescaler (
        .clk    (clk),
        .rst    (rst),
        .enable (enable),
        .clear  (resync),
        .tick   (tick)
    );

    function automatic logic [W-1:0] start_level(input int i);
        return W'(stagger_level(i, W, N));
    endfunction

    // One triangle step per channel, reflecting at both ends instead of wrapping.
    always_comb begin
        for (int i = 0; i < N; i++) begin
            // NOTE: defaults first so every path assigns and no latch is inferred.
            level_next[i]    = level[i];
            dir_down_next[i] = dir_down[i];
            if (!dir_down[i]) begin
                if (level[i] == MAX_LEVEL) begin
                    level_next[i]    = MAX_LEVEL - 1'b1;
                    dir_down_next[i] = 1'b1;
                end else begin
                    level_next[i] = level[i] + 1'b1;
                end
            end else begin
                if (level[i] == '0) begin
                    level_next[i]    = W'(1);
                    dir_down_next[i] = 1'b0;
                end else begin
                    level_next[i] = level[i] - 1'b1;
                end
            end
        end
    end

    // NOTE: the level array is a handful of flops, so reset loads the stagger pattern directly.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < N; i++) begin
                level[i]    <= start_level(i);
                dir_down[i] <= 1'b0;
            end
        end else if (resync) begin
            for (int i = 0; i < N; i++) begin
                level[i]    <= start_level(i);
                dir_down[i] <= 1'b0;
            end
        end else if (tick) begin
            for (int i = 0; i < N; i++) begin
                level[i]    <= level_next[i];
                dir_down[i] <= dir_down_next[i];
            end
        end
    end

    assign sel_inc = sel_thres + 1'b1;

    // Sweep FSM; the first entry into SWEEP publishes channel 0 with the value
    // that the level registers take on at that same edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= IDLE;
            init_pending <= 1'b1;
            new_thres    <= '0;
            sel_thres    <= '0;
            set_thres    <= 1'b0;
            busy         <= 1'b0;
        end else begin
            init_pending <= 1'b0;
            if (resync) begin
                state     <= SWEEP;
                sel_thres <= '0;
                new_thres <= start_level(0);
                set_thres <= 1'b1;
                busy      <= 1'b1;
            end else if (init_pending) begin
                state     <= SWEEP;
                sel_thres <= '0;
                new_thres <= level[0];
                set_thres <= 1'b1;
                busy      <= 1'b1;
            end else if (state == IDLE) begin
                if (tick) begin
                    state     <= SWEEP;
                    sel_thres <= '0;
                    new_thres <= level_next[0];
                    set_thres <= 1'b1;
                    busy      <= 1'b1;
                end
            end else if (sel_thres == LAST_SEL) begin
                state     <= IDLE;
                set_thres <= 1'b0;
                busy      <= 1'b0;
            end else begin
                sel_thres <= sel_inc;
                new_thres <= level[sel_inc];
            end
        end
    end

    no_tick_during_sweep: assert property (@(posedge clk) disable iff (!rst)
        !(tick && state == SWEEP))
        else $error("pulse_fader: tick arrived during a sweep; tick_div too small");

endmodule

// File: tb/tb_pulse_fader.sv
// Scoreboard bench for pulse_fader: stimulus queues expected writes, a monitor
// pops and compares them whenever set_thres is high.
module tb_pulse_fader;
    import pulsar_pkg::*;

    localparam int W      = 4;
    localparam int N      = 4;
    localparam int TD     = 8;
    localparam int SW     = $clog2(N);
    localparam int MAXL   = (1 << W) - 1;
    localparam int PERIOD = 2 * MAXL;

    logic          clk    = 1'b0;
    logic          rst    = 1'b0;
    logic          enable = 1'b0;
    logic          resync = 1'b0;
    logic [W-1:0]  new_thres;
    logic [SW-1:0] sel_thres;
    logic          set_thres;
    logic          busy;

    typedef struct {
        int sel;
        int thres;
    } wr_t;

    wr_t exp_q[$];
    wr_t mon_e;
    int  checks = 0;
    int  errors = 0;
    int  cyc;
    int  nw;
    int  run;

    pulse_fader #(.pwm_width(W), .num_pwm(N), .tick_div(TD)) dut (
        .clk       (clk),
        .rst       (rst),
        .enable    (enable),
        .resync    (resync),
        .new_thres (new_thres),
        .sel_thres (sel_thres),
        .set_thres (set_thres),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
        end
    endtask

    task automatic push_wr(input int s, input int t);
        wr_t e;
        e.sel   = s;
        e.thres = t;
        exp_q.push_back(e);
    endtask

    task automatic push_sweep(input int a, input int b, input int c, input int d);
        push_wr(0, a);
        push_wr(1, b);
        push_wr(2, c);
        push_wr(3, d);
    endtask

    // Closed-form triangle: level after k steps from start s, initially rising.
    function automatic int tri_level(input int s, input int k);
        int p;
        p = (s + k) % PERIOD;
        return (p <= MAXL) ? p : PERIOD - p;
    endfunction

    task automatic push_ramp(input int k);
        for (int i = 0; i < N; i++) push_wr(i, tri_level(stagger_level(i, W, N), k));
    endtask

    task automatic cycles_to_write(input int budget, output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!set_thres && n <= budget);
    endtask

    task automatic wait_sweeps(input int n, input int budget);
        int seen = 0;
        int c = 0;
        while (seen < n && c < budget) begin
            @(negedge clk);
            c++;
            if (set_thres && int'(sel_thres) == N - 1) seen++;
        end
        check("sweeps completed", seen, n);
    endtask

    always @(negedge clk) begin
        if (set_thres) begin
            check("write expected", int'(exp_q.size() > 0), 1);
            if (exp_q.size() > 0) begin
                mon_e = exp_q.pop_front();
                check("sel_thres", int'(sel_thres), mon_e.sel);
                check("new_thres", int'(new_thres), mon_e.thres);
            end
            check("busy during write", int'(busy), 1);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state and start-up sweep of the stagger levels.
        #12;
        check("reset set_thres", int'(set_thres), 0);
        check("reset busy", int'(busy), 0);
        check("reset new_thres", int'(new_thres), 0);
        check("reset sel_thres", int'(sel_thres), 0);
        push_sweep(0, 4, 8, 12);
        @(negedge clk);
        rst = 1'b1;
        cycles_to_write(5, cyc);
        check("start sweep latency", cyc, 1);
        wait_sweeps(1, 10);
        @(negedge clk);
        check("idle busy after start", int'(busy), 0);
        check("idle set after start", int'(set_thres), 0);

        // Ramp: top reflection at tick 4, bottom reflection of ch0 at tick 30/31.
        push_sweep(1, 5, 9, 13);
        push_sweep(2, 6, 10, 14);
        push_sweep(3, 7, 11, 15);
        push_sweep(4, 8, 12, 14);
        for (int k = 5; k <= 31; k++) push_ramp(k);
        enable = 1'b1;
        cycles_to_write(3 * TD, cyc);
        check("first tick latency", cyc, TD);
        wait_sweeps(31, 31 * TD + 20);

        // Disable mid-count: no writes, levels frozen, restart after a full tick_div.
        enable = 1'b0;
        nw = 0;
        repeat (100) begin
            @(negedge clk);
            if (set_thres) nw++;
        end
        check("writes while disabled", nw, 0);
        push_wr(0, tri_level(0, 32));
        push_wr(1, tri_level(4, 32));
        push_sweep(0, 4, 8, 12);
        enable = 1'b1;
        cycles_to_write(3 * TD, cyc);
        check("re-enable latency", cyc, TD);

        // Resync during the second sweep cycle restarts the sweep at sel 0.
        @(negedge clk);
        resync = 1'b1;
        @(negedge clk);
        resync = 1'b0;
        run = 0;
        while (set_thres && run < 10) begin
            run++;
            @(negedge clk);
        end
        check("resync sweep length", run, 4);
        check("busy after resync sweep", int'(busy), 0);
        push_ramp(1);
        wait_sweeps(1, 3 * TD);
        enable = 1'b0;

        // Resync coincident with a tick: stagger values win, prescaler restarts.
        repeat (2) @(negedge clk);
        push_sweep(0, 4, 8, 12);
        push_ramp(1);
        enable = 1'b1;
        repeat (TD - 1) @(negedge clk);
        resync = 1'b1;
        @(negedge clk);
        resync = 1'b0;
        wait_sweeps(2, 4 * TD);
        enable = 1'b0;

        // Asynchronous reset in the middle of a sweep.
        repeat (2) @(negedge clk);
        push_wr(0, 0);
        push_wr(1, 4);
        resync = 1'b1;
        @(negedge clk);
        resync = 1'b0;
        @(negedge clk);
        #2;
        rst = 1'b0;
        #1;
        check("async reset set_thres", int'(set_thres), 0);
        check("async reset busy", int'(busy), 0);
        check("async reset new_thres", int'(new_thres), 0);
        check("async reset sel_thres", int'(sel_thres), 0);
        push_sweep(0, 4, 8, 12);
        @(negedge clk);
        rst = 1'b1;
        cycles_to_write(5, cyc);
        check("restart sweep latency", cyc, 1);
        wait_sweeps(1, 10);
        @(negedge clk);
        check("idle busy after restart", int'(busy), 0);
        check("idle set after restart", int'(set_thres), 0);

        repeat (5) @(negedge clk);
        check("leftover expected writes", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
